// File: rtl/alu_operand_stage_pkg.sv
// Shared defaults and the issue packet type for the ALU operand stage.
package calvera_ex_pkg;

  localparam int LANES_DEF  = 2;
  localparam int XLEN_DEF   = 32;
  localparam int PREG_W_DEF = 6;
  localparam int ROB_W_DEF  = 5;
  localparam int OPC_W_DEF  = 4;

  // Issue packet at the default widths (rename/issue side view of one lane).
  typedef struct packed {
    logic [ROB_W_DEF-1:0]  rob;
    logic [PREG_W_DEF-1:0] dest;
    logic [OPC_W_DEF-1:0]  opc;
    logic [PREG_W_DEF-1:0] rs1;
    logic [PREG_W_DEF-1:0] rs2;
    logic                  imm_en;
    logic [XLEN_DEF-1:0]   imm;
  } alu_issue_t;

endpackage

// File: rtl/alu_operand_stage_if.sv
// One lane's issue/regfile/ALU bus. The issue side is the master, the lane is the slave.
interface alu_operand_stage_if
  import calvera_ex_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int PREG_W = PREG_W_DEF,
  parameter int ROB_W  = ROB_W_DEF,
  parameter int OPC_W  = OPC_W_DEF
) ();

  logic              iss_valid;
  logic              iss_ready;
  logic [ROB_W-1:0]  iss_rob;
  logic [PREG_W-1:0] iss_rs1;
  logic [PREG_W-1:0] iss_rs2;
  logic [PREG_W-1:0] iss_dest;
  logic [OPC_W-1:0]  iss_opc;
  logic              iss_imm_en;
  logic [XLEN-1:0]   iss_imm;
  logic [PREG_W-1:0] rf_rs1;
  logic [PREG_W-1:0] rf_rs2;
  logic [XLEN-1:0]   rf_rs1_data;
  logic [XLEN-1:0]   rf_rs2_data;
  logic              alu_valid;
  logic              alu_ready;
  logic [XLEN-1:0]   alu_a;
  logic [XLEN-1:0]   alu_b;
  logic [OPC_W-1:0]  alu_opc;
  logic [ROB_W-1:0]  alu_rob;
  logic [PREG_W-1:0] alu_dest;

  modport master (
    output iss_valid, iss_rob, iss_rs1, iss_rs2, iss_dest, iss_opc, iss_imm_en, iss_imm,
    output rf_rs1_data, rf_rs2_data, alu_ready,
    input  iss_ready, rf_rs1, rf_rs2, alu_valid, alu_a, alu_b, alu_opc, alu_rob, alu_dest
  );

  modport slave (
    input  iss_valid, iss_rob, iss_rs1, iss_rs2, iss_dest, iss_opc, iss_imm_en, iss_imm,
    input  rf_rs1_data, rf_rs2_data, alu_ready,
    output iss_ready, rf_rs1, rf_rs2, alu_valid, alu_a, alu_b, alu_opc, alu_rob, alu_dest
  );

endinterface

// File: rtl/alu_operand_stage_lane.sv
// One issue lane: one-entry output register with operand bypass from writeback,
// including refresh of operands while the packet is held by a stalled ALU.
module alu_operand_lane
  import calvera_ex_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int PREG_W = PREG_W_DEF,
  parameter int ROB_W  = ROB_W_DEF,
  parameter int OPC_W  = OPC_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              flush_i,
  input  logic              wb_valid_i,
  input  logic [PREG_W-1:0] wb_dest_i,
  input  logic [XLEN-1:0]   wb_data_i,
  alu_operand_stage_if.slave lane_bus
);

  logic              valid_q, valid_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [OPC_W-1:0]  opc_q, opc_d;
  logic [ROB_W-1:0]  rob_q, rob_d;
  logic [PREG_W-1:0] dest_q, dest_d;
  logic [PREG_W-1:0] rs1_q, rs1_d;
  logic [PREG_W-1:0] rs2_q, rs2_d;
  logic              b_imm_q, b_imm_d;

  logic ready;
  logic accept;
  logic stall;
  logic wb_live;

  // x0 reads as zero, so a writeback to it is never a forwarding source.
  function automatic logic [XLEN-1:0] src_value(
    input logic [PREG_W-1:0] idx,
    input logic [XLEN-1:0]   rf_data,
    input logic              wbv,
    input logic [PREG_W-1:0] wbd,
    input logic [XLEN-1:0]   wbdata
  );
    if (idx == '0)                return '0;
    else if (wbv && (wbd == idx)) return wbdata;
    else                          return rf_data;
  endfunction

  assign ready   = !valid_q || lane_bus.alu_ready;
  assign accept  = lane_bus.iss_valid && ready && !flush_i;
  assign stall   = valid_q && !lane_bus.alu_ready;
  assign wb_live = wb_valid_i && (wb_dest_i != '0);

  // Next state: flush beats accept, accept beats hold/refresh, a completed handshake drains.
  always_comb begin
    valid_d = valid_q;
    a_d     = a_q;
    b_d     = b_q;
    opc_d   = opc_q;
    rob_d   = rob_q;
    dest_d  = dest_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    b_imm_d = b_imm_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      a_d     = src_value(lane_bus.iss_rs1, lane_bus.rf_rs1_data, wb_valid_i, wb_dest_i, wb_data_i);
      b_d     = lane_bus.iss_imm_en ? lane_bus.iss_imm :
                src_value(lane_bus.iss_rs2, lane_bus.rf_rs2_data, wb_valid_i, wb_dest_i, wb_data_i);
      opc_d   = lane_bus.iss_opc;
      rob_d   = lane_bus.iss_rob;
      dest_d  = lane_bus.iss_dest;
      rs1_d   = lane_bus.iss_rs1;
      rs2_d   = lane_bus.iss_rs2;
      b_imm_d = lane_bus.iss_imm_en;
    end else if (stall) begin
      if (wb_live && (wb_dest_i == rs1_q))             a_d = wb_data_i;
      if (wb_live && !b_imm_q && (wb_dest_i == rs2_q)) b_d = wb_data_i;
    end else if (valid_q) begin
      valid_d = 1'b0;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      opc_q   <= '0;
      rob_q   <= '0;
      dest_q  <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      b_imm_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      opc_q   <= opc_d;
      rob_q   <= rob_d;
      dest_q  <= dest_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      b_imm_q <= b_imm_d;
    end
  end

  assign lane_bus.iss_ready = ready;
  assign lane_bus.rf_rs1    = lane_bus.iss_rs1;
  assign lane_bus.rf_rs2    = lane_bus.iss_rs2;
  assign lane_bus.alu_valid = valid_q;
  assign lane_bus.alu_a     = a_q;
  assign lane_bus.alu_b     = b_q;
  assign lane_bus.alu_opc   = opc_q;
  assign lane_bus.alu_rob   = rob_q;
  assign lane_bus.alu_dest  = dest_q;

endmodule

// File: rtl/alu_operand_stage.sv
// Multi-lane ALU operand stage: unpacks the flat per-lane buses onto one
// lane interface each and runs an independent operand lane behind it.
module alu_operand_stage
  import calvera_ex_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int XLEN   = XLEN_DEF,
  parameter int PREG_W = PREG_W_DEF,
  parameter int ROB_W  = ROB_W_DEF,
  parameter int OPC_W  = OPC_W_DEF
) (
  input  logic                    cpu_clock_i,
  input  logic                    cpu_reset_n_i,
  input  logic                    flush_i,
  input  logic [LANES-1:0]        iss_valid_i,
  output logic [LANES-1:0]        iss_ready_o,
  input  logic [LANES*ROB_W-1:0]  iss_rob_i,
  input  logic [LANES*PREG_W-1:0] iss_rs1_i,
  input  logic [LANES*PREG_W-1:0] iss_rs2_i,
  input  logic [LANES*PREG_W-1:0] iss_dest_i,
  input  logic [LANES*OPC_W-1:0]  iss_opc_i,
  input  logic [LANES-1:0]        iss_imm_en_i,
  input  logic [LANES*XLEN-1:0]   iss_imm_i,
  output logic [LANES*PREG_W-1:0] rf_rs1_o,
  output logic [LANES*PREG_W-1:0] rf_rs2_o,
  input  logic [LANES*XLEN-1:0]   rf_rs1_data_i,
  input  logic [LANES*XLEN-1:0]   rf_rs2_data_i,
  input  logic                    wb_valid_i,
  input  logic [PREG_W-1:0]       wb_dest_i,
  input  logic [XLEN-1:0]         wb_data_i,
  output logic [LANES-1:0]        alu_valid_o,
  input  logic [LANES-1:0]        alu_ready_i,
  output logic [LANES*XLEN-1:0]   alu_a_o,
  output logic [LANES*XLEN-1:0]   alu_b_o,
  output logic [LANES*OPC_W-1:0]  alu_opc_o,
  output logic [LANES*ROB_W-1:0]  alu_rob_o,
  output logic [LANES*PREG_W-1:0] alu_dest_o
);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    alu_operand_stage_if #(.XLEN(XLEN), .PREG_W(PREG_W), .ROB_W(ROB_W), .OPC_W(OPC_W)) lane_if ();

    assign lane_if.iss_valid   = iss_valid_i[gi];
    assign lane_if.iss_rob     = iss_rob_i[gi*ROB_W +: ROB_W];
    assign lane_if.iss_rs1     = iss_rs1_i[gi*PREG_W +: PREG_W];
    assign lane_if.iss_rs2     = iss_rs2_i[gi*PREG_W +: PREG_W];
    assign lane_if.iss_dest    = iss_dest_i[gi*PREG_W +: PREG_W];
    assign lane_if.iss_opc     = iss_opc_i[gi*OPC_W +: OPC_W];
    assign lane_if.iss_imm_en  = iss_imm_en_i[gi];
    assign lane_if.iss_imm     = iss_imm_i[gi*XLEN +: XLEN];
    assign lane_if.rf_rs1_data = rf_rs1_data_i[gi*XLEN +: XLEN];
    assign lane_if.rf_rs2_data = rf_rs2_data_i[gi*XLEN +: XLEN];
    assign lane_if.alu_ready   = alu_ready_i[gi];

    assign iss_ready_o[gi]                  = lane_if.iss_ready;
    assign rf_rs1_o[gi*PREG_W +: PREG_W]    = lane_if.rf_rs1;
    assign rf_rs2_o[gi*PREG_W +: PREG_W]    = lane_if.rf_rs2;
    assign alu_valid_o[gi]                  = lane_if.alu_valid;
    assign alu_a_o[gi*XLEN +: XLEN]         = lane_if.alu_a;
    assign alu_b_o[gi*XLEN +: XLEN]         = lane_if.alu_b;
    assign alu_opc_o[gi*OPC_W +: OPC_W]     = lane_if.alu_opc;
    assign alu_rob_o[gi*ROB_W +: ROB_W]     = lane_if.alu_rob;
    assign alu_dest_o[gi*PREG_W +: PREG_W]  = lane_if.alu_dest;

    alu_operand_lane #(.XLEN(XLEN), .PREG_W(PREG_W), .ROB_W(ROB_W), .OPC_W(OPC_W)) u_lane (
      .clk_i      (cpu_clock_i),
      .rst_n_i    (cpu_reset_n_i),
      .flush_i    (flush_i),
      .wb_valid_i (wb_valid_i),
      .wb_dest_i  (wb_dest_i),
      .wb_data_i  (wb_data_i),
      .lane_bus   (lane_if.slave)
    );
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: reset, directed vector table, hand-written
// multi-cycle sequences, then randomized traffic against a reference model.
module tb_alu_operand_stage;
  import calvera_ex_pkg::*;

  localparam int LANES  = LANES_DEF;
  localparam int XLEN   = XLEN_DEF;
  localparam int PREG_W = PREG_W_DEF;
  localparam int ROB_W  = ROB_W_DEF;
  localparam int OPC_W  = OPC_W_DEF;

  logic                    cpu_clock_i = 1'b0;
  logic                    cpu_reset_n_i;
  logic                    flush_i;
  logic [LANES-1:0]        iss_valid_i;
  logic [LANES-1:0]        iss_ready_o;
  logic [LANES*ROB_W-1:0]  iss_rob_i;
  logic [LANES*PREG_W-1:0] iss_rs1_i, iss_rs2_i, iss_dest_i;
  logic [LANES*OPC_W-1:0]  iss_opc_i;
  logic [LANES-1:0]        iss_imm_en_i;
  logic [LANES*XLEN-1:0]   iss_imm_i;
  logic [LANES*PREG_W-1:0] rf_rs1_o, rf_rs2_o;
  logic [LANES*XLEN-1:0]   rf_rs1_data_i, rf_rs2_data_i;
  logic                    wb_valid_i;
  logic [PREG_W-1:0]       wb_dest_i;
  logic [XLEN-1:0]         wb_data_i;
  logic [LANES-1:0]        alu_valid_o;
  logic [LANES-1:0]        alu_ready_i;
  logic [LANES*XLEN-1:0]   alu_a_o, alu_b_o;
  logic [LANES*OPC_W-1:0]  alu_opc_o;
  logic [LANES*ROB_W-1:0]  alu_rob_o;
  logic [LANES*PREG_W-1:0] alu_dest_o;

  always #5 cpu_clock_i = ~cpu_clock_i;

  alu_operand_stage #(.LANES(LANES), .XLEN(XLEN), .PREG_W(PREG_W), .ROB_W(ROB_W), .OPC_W(OPC_W)) dut (
    .cpu_clock_i(cpu_clock_i), .cpu_reset_n_i(cpu_reset_n_i), .flush_i(flush_i),
    .iss_valid_i(iss_valid_i), .iss_ready_o(iss_ready_o), .iss_rob_i(iss_rob_i),
    .iss_rs1_i(iss_rs1_i), .iss_rs2_i(iss_rs2_i), .iss_dest_i(iss_dest_i), .iss_opc_i(iss_opc_i),
    .iss_imm_en_i(iss_imm_en_i), .iss_imm_i(iss_imm_i), .rf_rs1_o(rf_rs1_o), .rf_rs2_o(rf_rs2_o),
    .rf_rs1_data_i(rf_rs1_data_i), .rf_rs2_data_i(rf_rs2_data_i), .wb_valid_i(wb_valid_i),
    .wb_dest_i(wb_dest_i), .wb_data_i(wb_data_i), .alu_valid_o(alu_valid_o), .alu_ready_i(alu_ready_i),
    .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_opc_o(alu_opc_o), .alu_rob_o(alu_rob_o),
    .alu_dest_o(alu_dest_o)
  );

  // Per-lane view of the ports through the lane interface; logs each ALU transfer.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_mon
    alu_operand_stage_if #(.XLEN(XLEN), .PREG_W(PREG_W), .ROB_W(ROB_W), .OPC_W(OPC_W)) mon ();
    assign mon.iss_valid   = iss_valid_i[gi];
    assign mon.iss_ready   = iss_ready_o[gi];
    assign mon.iss_rob     = iss_rob_i[gi*ROB_W +: ROB_W];
    assign mon.iss_rs1     = iss_rs1_i[gi*PREG_W +: PREG_W];
    assign mon.iss_rs2     = iss_rs2_i[gi*PREG_W +: PREG_W];
    assign mon.iss_dest    = iss_dest_i[gi*PREG_W +: PREG_W];
    assign mon.iss_opc     = iss_opc_i[gi*OPC_W +: OPC_W];
    assign mon.iss_imm_en  = iss_imm_en_i[gi];
    assign mon.iss_imm     = iss_imm_i[gi*XLEN +: XLEN];
    assign mon.rf_rs1      = rf_rs1_o[gi*PREG_W +: PREG_W];
    assign mon.rf_rs2      = rf_rs2_o[gi*PREG_W +: PREG_W];
    assign mon.rf_rs1_data = rf_rs1_data_i[gi*XLEN +: XLEN];
    assign mon.rf_rs2_data = rf_rs2_data_i[gi*XLEN +: XLEN];
    assign mon.alu_valid   = alu_valid_o[gi];
    assign mon.alu_ready   = alu_ready_i[gi];
    assign mon.alu_a       = alu_a_o[gi*XLEN +: XLEN];
    assign mon.alu_b       = alu_b_o[gi*XLEN +: XLEN];
    assign mon.alu_opc     = alu_opc_o[gi*OPC_W +: OPC_W];
    assign mon.alu_rob     = alu_rob_o[gi*ROB_W +: ROB_W];
    assign mon.alu_dest    = alu_dest_o[gi*PREG_W +: PREG_W];

    always @(posedge cpu_clock_i) begin
      if (cpu_reset_n_i && mon.alu_valid && mon.alu_ready)
        $display("lane%0d xfer rob=%0d dest=%0d opc=%0d a=%08h b=%08h", gi,
                 mon.alu_rob, mon.alu_dest, mon.alu_opc, mon.alu_a, mon.alu_b);
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] out_a(input int l);    return alu_a_o[l*XLEN +: XLEN];       endfunction
  function automatic logic [XLEN-1:0] out_b(input int l);    return alu_b_o[l*XLEN +: XLEN];       endfunction
  function automatic logic [ROB_W-1:0] out_rob(input int l); return alu_rob_o[l*ROB_W +: ROB_W];   endfunction
  function automatic logic [PREG_W-1:0] out_dest(input int l); return alu_dest_o[l*PREG_W +: PREG_W]; endfunction
  function automatic logic [OPC_W-1:0] out_opc(input int l); return alu_opc_o[l*OPC_W +: OPC_W];   endfunction

  function automatic alu_issue_t mk(input int rob, input int dest, input int opc, input int rs1,
                                    input int rs2, input logic imm_en, input logic [XLEN-1:0] imm);
    alu_issue_t p;
    p.rob = ROB_W'(rob); p.dest = PREG_W'(dest); p.opc = OPC_W'(opc);
    p.rs1 = PREG_W'(rs1); p.rs2 = PREG_W'(rs2); p.imm_en = imm_en; p.imm = imm;
    return p;
  endfunction

  task automatic set_issue(input int l, input alu_issue_t p, input logic [XLEN-1:0] rf1, input logic [XLEN-1:0] rf2);
    iss_valid_i[l]                    = 1'b1;
    iss_rob_i[l*ROB_W +: ROB_W]       = p.rob;
    iss_dest_i[l*PREG_W +: PREG_W]    = p.dest;
    iss_opc_i[l*OPC_W +: OPC_W]       = p.opc;
    iss_rs1_i[l*PREG_W +: PREG_W]     = p.rs1;
    iss_rs2_i[l*PREG_W +: PREG_W]     = p.rs2;
    iss_imm_en_i[l]                   = p.imm_en;
    iss_imm_i[l*XLEN +: XLEN]         = p.imm;
    rf_rs1_data_i[l*XLEN +: XLEN]     = rf1;
    rf_rs2_data_i[l*XLEN +: XLEN]     = rf2;
  endtask

  task automatic idle();
    flush_i = 1'b0; iss_valid_i = '0; iss_rob_i = '0; iss_rs1_i = '0; iss_rs2_i = '0;
    iss_dest_i = '0; iss_opc_i = '0; iss_imm_en_i = '0; iss_imm_i = '0;
    rf_rs1_data_i = '0; rf_rs2_data_i = '0; wb_valid_i = 1'b0; wb_dest_i = '0; wb_data_i = '0;
    alu_ready_i = '1;
  endtask

  task automatic tick();
    @(posedge cpu_clock_i);
    #1;
  endtask

  task automatic set_wb(input logic v, input int d, input logic [XLEN-1:0] data);
    wb_valid_i = v; wb_dest_i = PREG_W'(d); wb_data_i = data;
  endtask

  typedef struct {
    int              lane;
    alu_issue_t      p;
    logic [XLEN-1:0] rf1, rf2;
    logic            wbv;
    int              wbd;
    logic [XLEN-1:0] wbdata;
    logic [XLEN-1:0] exp_a, exp_b;
  } vec_t;

  // Reference model state: the packet each lane currently presents to its ALU.
  logic            m_valid [LANES];
  logic [XLEN-1:0] m_a [LANES], m_b [LANES];
  logic [OPC_W-1:0] m_opc [LANES];
  logic [ROB_W-1:0] m_rob [LANES];
  logic [PREG_W-1:0] m_dest [LANES], m_src1 [LANES], m_src2 [LANES];
  logic            m_bimm [LANES];
  logic [XLEN-1:0] regs [64];

  // Value of a source register as seen this cycle.
  function automatic logic [XLEN-1:0] ref_src(input logic [PREG_W-1:0] idx, input logic [XLEN-1:0] rfd);
    if (idx == 0) return '0;
    if (wb_valid_i && wb_dest_i == idx) return wb_data_i;
    return rfd;
  endfunction

  initial begin
    vec_t vecs[6];
    alu_issue_t p;

    vecs[0] = '{lane:0, p:mk(1, 10, 2, 3, 4, 1'b0, 0), rf1:32'h11, rf2:32'h22,
                wbv:1'b0, wbd:0, wbdata:32'h0, exp_a:32'h11, exp_b:32'h22};
    vecs[1] = '{lane:0, p:mk(2, 11, 3, 5, 6, 1'b0, 0), rf1:32'h99, rf2:32'h66,
                wbv:1'b1, wbd:5, wbdata:32'hAB, exp_a:32'hAB, exp_b:32'h66};
    vecs[2] = '{lane:0, p:mk(3, 12, 4, 0, 2, 1'b0, 0), rf1:32'h77, rf2:32'h2222,
                wbv:1'b1, wbd:0, wbdata:32'hCD, exp_a:32'h0, exp_b:32'h2222};
    vecs[3] = '{lane:1, p:mk(4, 13, 5, 0, 0, 1'b0, 0), rf1:32'h33, rf2:32'h44,
                wbv:1'b1, wbd:0, wbdata:32'hCD, exp_a:32'h0, exp_b:32'h0};
    vecs[4] = '{lane:1, p:mk(5, 14, 6, 9, 9, 1'b1, 32'hDEADBEEF), rf1:32'h1, rf2:32'h2,
                wbv:1'b1, wbd:9, wbdata:32'h5A, exp_a:32'h5A, exp_b:32'hDEADBEEF};
    vecs[5] = '{lane:1, p:mk(6, 15, 7, 12, 8, 1'b0, 0), rf1:32'h10, rf2:32'h20,
                wbv:1'b1, wbd:8, wbdata:32'h1234, exp_a:32'h10, exp_b:32'h1234};

    // Reset, with traffic and flush asserted to show reset wins.
    idle();
    cpu_reset_n_i = 1'b0;
    iss_valid_i = '1; flush_i = 1'b1;
    repeat (3) tick();
    chk("rst_valid", alu_valid_o, 0);
    chk("rst_a", alu_a_o, 0);
    chk("rst_b", alu_b_o, 0);
    chk("rst_dest_rob", {alu_dest_o, alu_rob_o, alu_opc_o}, 0);
    idle();
    alu_ready_i = '0;
    cpu_reset_n_i = 1'b1;
    tick();
    chk("post_rst_ready", iss_ready_o, 2'b11);
    chk("post_rst_valid", alu_valid_o, 0);

    // Directed vector table: single issue, drain the following cycle.
    for (int i = 0; i < 6; i++) begin
      idle();
      set_issue(vecs[i].lane, vecs[i].p, vecs[i].rf1, vecs[i].rf2);
      set_wb(vecs[i].wbv, vecs[i].wbd, vecs[i].wbdata);
      #1;
      chk($sformatf("v%0d_rf_addr", i), {rf_rs1_o[vecs[i].lane*PREG_W +: PREG_W], rf_rs2_o[vecs[i].lane*PREG_W +: PREG_W]},
          {vecs[i].p.rs1, vecs[i].p.rs2});
      chk($sformatf("v%0d_iss_ready", i), iss_ready_o[vecs[i].lane], 1);
      tick();
      idle();
      chk($sformatf("v%0d_valid", i), alu_valid_o, 2'b1 << vecs[i].lane);
      chk($sformatf("v%0d_a", i), out_a(vecs[i].lane), vecs[i].exp_a);
      chk($sformatf("v%0d_b", i), out_b(vecs[i].lane), vecs[i].exp_b);
      chk($sformatf("v%0d_meta", i), {out_rob(vecs[i].lane), out_dest(vecs[i].lane), out_opc(vecs[i].lane)},
          {vecs[i].p.rob, vecs[i].p.dest, vecs[i].p.opc});
      $display("vec %0d lane%0d a=%08h b=%08h", i, vecs[i].lane, out_a(vecs[i].lane), out_b(vecs[i].lane));
      tick();
      chk($sformatf("v%0d_drain", i), alu_valid_o, 0);
    end

    // Stall with writeback refresh of held sources.
    idle();
    alu_ready_i[0] = 1'b0;
    set_issue(0, mk(3, 20, 5, 6, 7, 1'b0, 0), 32'h60, 32'h70);
    tick();
    iss_valid_i = '0;
    chk("stall_load_a", out_a(0), 32'h60);
    chk("stall_load_b", out_b(0), 32'h70);
    #1;
    chk("stall_ready", iss_ready_o[0], 0);
    set_issue(0, mk(9, 30, 9, 1, 2, 1'b0, 0), 32'hEE, 32'hFF);
    set_wb(1'b1, 7, 32'h55);
    tick();
    chk("stall_b_refresh", out_b(0), 32'h55);
    chk("stall_a_held", out_a(0), 32'h60);
    chk("stall_meta_held", {out_rob(0), out_dest(0), out_opc(0)}, {5'd3, 6'd20, 4'd5});
    chk("stall_valid", alu_valid_o[0], 1);
    set_wb(1'b1, 6, 32'h66);
    tick();
    chk("stall_a_refresh", out_a(0), 32'h66);
    chk("stall_b_kept", out_b(0), 32'h55);
    idle();
    tick();
    chk("stall_release", alu_valid_o, 0);

    // Back-to-back on lane0 while lane1 sits stalled.
    idle();
    alu_ready_i = 2'b01;
    set_issue(1, mk(30, 31, 1, 2, 0, 1'b0, 0), 32'h222, 32'h0);
    for (int k = 0; k < 4; k++) begin
      set_issue(0, mk(8 + k, 40 + k, k, k + 1, 0, 1'b0, 0), 32'h100 + k, 32'h0);
      #1;
      chk($sformatf("b2b%0d_ready0", k), iss_ready_o[0], 1);
      tick();
      iss_valid_i[1] = 1'b0;
      chk($sformatf("b2b%0d_valid0", k), alu_valid_o[0], 1);
      chk($sformatf("b2b%0d_a0", k), out_a(0), 32'h100 + k);
      chk($sformatf("b2b%0d_rob0", k), out_rob(0), 8 + k);
    end
    iss_valid_i[0] = 1'b0;
    #1;
    chk("b2b_ready1", iss_ready_o[1], 0);
    tick();
    chk("b2b_drain", alu_valid_o, 2'b10);
    chk("b2b_lane1_a", out_a(1), 32'h222);

    // Flush during stall plus concurrent issue on both lanes.
    alu_ready_i = 2'b00;
    set_issue(0, mk(1, 1, 1, 1, 1, 1'b0, 0), 32'h1, 32'h1);
    tick();
    iss_valid_i = '0;
    chk("fl_pre_valid", alu_valid_o, 2'b11);
    flush_i = 1'b1;
    set_issue(0, mk(2, 2, 2, 2, 2, 1'b0, 0), 32'h2, 32'h2);
    set_issue(1, mk(3, 3, 3, 3, 3, 1'b0, 0), 32'h3, 32'h3);
    tick();
    flush_i = 1'b0; iss_valid_i = '0;
    chk("fl_valid", alu_valid_o, 0);
    tick();
    chk("fl_not_accepted", alu_valid_o, 0);
    chk("fl_ready", iss_ready_o, 2'b11);

    // Reset mid-stall, then first issue after reset.
    idle();
    alu_ready_i = '0;
    set_issue(0, mk(7, 9, 3, 3, 4, 1'b0, 0), 32'h31, 32'h41);
    tick();
    chk("rs_pre_valid", alu_valid_o[0], 1);
    cpu_reset_n_i = 1'b0;
    tick();
    chk("rs_valid", alu_valid_o, 0);
    chk("rs_data", {out_a(0), out_b(0)}, 0);
    chk("rs_meta", {out_rob(0), out_dest(0)}, 0);
    cpu_reset_n_i = 1'b1;
    alu_ready_i = '1;
    #1;
    chk("rs_ready", iss_ready_o[0], 1);
    tick();
    chk("rs_first_valid", alu_valid_o[0], 1);
    chk("rs_first_a", out_a(0), 32'h31);
    idle();
    tick();

    // Randomized traffic against the reference model.
    for (int l = 0; l < LANES; l++) begin
      m_valid[l] = 1'b0; m_a[l] = '0; m_b[l] = '0; m_opc[l] = '0; m_rob[l] = '0;
      m_dest[l] = '0; m_src1[l] = '0; m_src2[l] = '0; m_bimm[l] = 1'b0;
    end
    for (int r = 0; r < 64; r++) regs[r] = $urandom;
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic [PREG_W-1:0] s1, s2;
      logic rdy;
      flush_i    = ($urandom_range(0, 19) == 0);
      wb_valid_i = $urandom_range(0, 1) == 1;
      wb_dest_i  = PREG_W'($urandom_range(0, 7));
      wb_data_i  = $urandom;
      for (int l = 0; l < LANES; l++) begin
        p = mk($urandom, $urandom, $urandom, $urandom_range(0, 7), $urandom_range(0, 7),
               $urandom_range(0, 3) == 0, $urandom);
        set_issue(l, p, regs[p.rs1], regs[p.rs2]);
        iss_valid_i[l] = $urandom_range(0, 9) < 7;
        alu_ready_i[l] = $urandom_range(0, 9) < 6;
      end
      #1;
      for (int l = 0; l < LANES; l++) begin
        rdy = !m_valid[l] || alu_ready_i[l];
        chk($sformatf("rnd%0d_l%0d_ready", cyc, l), iss_ready_o[l], rdy);
        s1 = iss_rs1_i[l*PREG_W +: PREG_W];
        s2 = iss_rs2_i[l*PREG_W +: PREG_W];
        if (flush_i) begin
          m_valid[l] = 1'b0;
        end else if (iss_valid_i[l] && rdy) begin
          m_valid[l] = 1'b1;
          m_a[l]    = ref_src(s1, rf_rs1_data_i[l*XLEN +: XLEN]);
          m_b[l]    = iss_imm_en_i[l] ? iss_imm_i[l*XLEN +: XLEN] : ref_src(s2, rf_rs2_data_i[l*XLEN +: XLEN]);
          m_opc[l]  = iss_opc_i[l*OPC_W +: OPC_W];
          m_rob[l]  = iss_rob_i[l*ROB_W +: ROB_W];
          m_dest[l] = iss_dest_i[l*PREG_W +: PREG_W];
          m_src1[l] = s1; m_src2[l] = s2; m_bimm[l] = iss_imm_en_i[l];
        end else if (m_valid[l] && !alu_ready_i[l]) begin
          if (m_src1[l] != 0) m_a[l] = ref_src(m_src1[l], m_a[l]);
          if (!m_bimm[l] && m_src2[l] != 0) m_b[l] = ref_src(m_src2[l], m_b[l]);
        end else begin
          m_valid[l] = 1'b0;
        end
      end
      if (wb_valid_i && wb_dest_i != 0) regs[wb_dest_i] = wb_data_i;
      tick();
      for (int l = 0; l < LANES; l++) begin
        chk($sformatf("rnd%0d_l%0d_valid", cyc, l), alu_valid_o[l], m_valid[l]);
        if (m_valid[l]) begin
          chk($sformatf("rnd%0d_l%0d_a", cyc, l), out_a(l), m_a[l]);
          chk($sformatf("rnd%0d_l%0d_b", cyc, l), out_b(l), m_b[l]);
          chk($sformatf("rnd%0d_l%0d_meta", cyc, l), {out_rob(l), out_dest(l), out_opc(l)},
              {m_rob[l], m_dest[l], m_opc[l]});
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  LANES, 2, independent issue lanes
  XLEN, 32, operand width
  PREG_W, 6, physical register index width
  ROB_W, 5, ROB tag width
  OPC_W, 4, ALU opcode width
REQ-002 Ports, one per line: name  direction  width  meaning; clock and reset first; [L] = per lane, packed LANES×width.
  cpu_clock_i  in  1  the block's only clock
  cpu_reset_n_i  in  1  reset, synchronous to cpu_clock_i, active-low
  flush_i  in  1  pipeline flush
  iss_valid_i[L]  in  1  issue packet valid
  iss_ready_o[L]  out  1  lane accepts packet
  iss_rob_i[L]  in  ROB_W  ROB tag
  iss_rs1_i[L], iss_rs2_i[L]  in  PREG_W  source registers
  iss_dest_i[L]  in  PREG_W  destination register
  iss_opc_i[L]  in  OPC_W  opcode
  iss_imm_en_i[L]  in  1  use immediate as operand B
  iss_imm_i[L]  in  XLEN  immediate
  rf_rs1_o[L], rf_rs2_o[L]  out  PREG_W  regfile read addresses
  rf_rs1_data_i[L], rf_rs2_data_i[L]  in  XLEN  same-cycle regfile data
  wb_valid_i  in  1  writeback valid
  wb_dest_i  in  PREG_W  writeback register
  wb_data_i  in  XLEN  writeback data
  alu_valid_o[L]  out  1  ALU packet valid
  alu_ready_i[L]  in  1  ALU accepts packet
  alu_a_o[L], alu_b_o[L]  out  XLEN  operands
  alu_opc_o[L]  out  OPC_W  opcode
  alu_rob_o[L]  out  ROB_W  ROB tag
  alu_dest_o[L]  out  PREG_W  destination

Function
REQ-003 rf_rs1_o/rf_rs2_o SHALL combinationally equal iss_rs1_i/iss_rs2_i per lane.
REQ-004 Each lane SHALL be a one-entry output register with valid/ready handshake; lanes fully independent.
REQ-005 iss_ready_o SHALL equal !alu_valid_o | alu_ready_i (combinational, per lane); it SHALL NOT depend on iss_valid_i.
REQ-006 Accept = iss_valid_i & iss_ready_o & !flush_i; on accept, output fields SHALL load next cycle, alu_valid_o=1 (latency 1 cycle).
REQ-007 Operand A = 0 if rs1==0; else wb_data_i if wb_valid_i & wb_dest_i==rs1; else rf_rs1_data_i.
REQ-008 Operand B = iss_imm_i if iss_imm_en_i; else same rule as REQ-007 on rs2.
REQ-009 Writeback with wb_dest_i==0 SHALL never forward.
REQ-010 alu_valid_o & !alu_ready_i (stall): all outputs SHALL hold unchanged; no input accepted.
REQ-011 Stalled operands SHALL refresh from writeback: while held, if wb_valid_i & wb_dest_i!=0 matches a held source register (not immediate B), that operand SHALL update to wb_data_i. Held rs1/rs2 indices kept internally.
REQ-012 Handshake completes when alu_ready_i & alu_valid_o; absent new accept same cycle, alu_valid_o SHALL clear next cycle.
REQ-013 Simultaneous drain and accept SHALL load new packet, alu_valid_o stays 1 (full throughput).
REQ-014 flush_i SHALL clear every alu_valid_o next cycle, override accept and stall; data fields don't-care.

Reset
REQ-015 cpu_reset_n_i low at a clock edge SHALL clear all alu_valid_o and held register indices; data outputs SHALL reset to 0.
REQ-016 Reset SHALL take priority over flush_i and accept; iss_ready_o SHALL be 1 the cycle after reset deasserts.

Structure
REQ-017 Package calvera_ex_pkg SHALL hold parameter defaults and the alu_issue_t packet struct (rob, dest, opc, rs1, rs2, imm_en, imm).
REQ-018 One sub-module alu_operand_lane SHALL implement REQ-004..REQ-014 for one lane, instantiated LANES times via generate.

Verification
REQ-019 Lane0 issue rs1=3 (rf 0x11), rs2=4 (rf 0x22), imm_en=0, ready=1 -> next cycle a=0x11, b=0x22, valid=1.
REQ-020 Issue rs1=5, wb_valid=1 wb_dest=5 wb_data=0xAB same cycle -> a=0xAB; repeat wb_dest=0 with rs1=0 -> a=0.
REQ-021 alu_ready_i=0 with held rs2=7, imm_en=0; wb dest 7 data 0x55 -> b becomes 0x55, iss_ready_o=0, other fields unchanged.
REQ-022 Back-to-back issue 4 packets, ready=1 -> 4 consecutive valid outputs, no bubble; lane1 stalled does not stall lane0.
REQ-023 flush_i during valid+stall and concurrent issue -> all alu_valid_o=0 next cycle, packet not accepted.
REQ-024 Reset asserted mid-stall -> outputs 0, valid 0; first post-reset issue accepted.
